mem_port_ctrl: RTL and testbench

Load/store controller between the CPU datapath and port A of the 1024×16 `dpram`. It accepts one CPU memory request at a time and sequences it onto the RAM port with correct timing for the RAM's registered output. It returns read data with a single-cycle `ack`. Port B of the RAM stays free for the display or another consumer. An optional memory-mapped I/O window diverts the top of the address space to an I/O register and an input bus.

---
 rtl/mem_port_ctrl.sv | 126 ++++++++++++
 tb/tb_mem_port_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: load/store sequencer between the CPU datapath and port A of
// the 1024x16 dpram. It runs one request at a time through a fixed
// IDLE -> ACCESS -> WAIT -> RESP cycle. The extra WAIT state absorbs the
// RAM's registered read output.
// Optional build macro MEM_CTRL_MMIO_EN enables a memory-mapped I/O window
// at the top of the address space. When this macro is defined, the window
// maps loads to io_in and stores to the io_out register.
module mem_port_ctrl #(
    parameter int DATA_W = 16,
    parameter int RAM_AW = 10,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              io_hit;
    logic [DATA_W-1:0] load_val;

    // The I/O window is every address whose bits above the RAM index are all ones.
    function automatic logic window_hit(input logic [ADDR_W-1:0] a);
        return &a[ADDR_W-1:RAM_AW];
    endfunction

    // The RAM port always reflects the latched request. Upper address bits alias onto the RAM.
    assign ram_addr = addr_q[RAM_AW-1:0];
    assign ram_din  = wdata_q;

    // A write strobe is issued only in ACCESS, and never for an access that targets the I/O window.
    assign ram_we = (state == ACCESS) && we_q && !io_hit;

`ifdef MEM_CTRL_MMIO_EN
    logic [DATA_W-1:0] io_out_q;

    assign io_hit   = window_hit(addr_q);
    assign load_val = io_hit ? io_in : ram_dout;
    assign io_out   = io_out_q;

    // I/O output register: loaded by a store into the window when WAIT exits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_out_q <= '0;
        end else if (state == WAIT && we_q && io_hit) begin
            io_out_q <= wdata_q;
        end
    end
`else
    logic unused_io;

    assign io_hit    = 1'b0;
    assign load_val  = ram_dout;
    assign io_out    = '0;
    // Without the window the input bus and the upper address bits have no consumer.
    assign unused_io = ^{io_in, addr_q[ADDR_W-1:RAM_AW], window_hit(addr_q)};
`endif

    // Request sequencer: latch in IDLE, then run a fixed four-cycle access with registered ack, busy and rdata.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata   <= '0;
            ack     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        we_q    <= we;
                        wdata_q <= wdata;
                        busy    <= 1'b1;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // ram_dout now shows the word addressed during ACCESS.
                    if (!we_q) begin
                        rdata <= load_val;
                    end
                    ack   <= 1'b1;
                    state <= RESP;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: scoreboard bench for mem_port_ctrl. A behavioural
// 1024x16 RAM with a registered read stands in for dpram. The driver pushes
// expected results from a word-level reference model. A monitor then pops
// and compares those results on every ack.
module tb_mem_port_ctrl;

    localparam int DATA_W = 16;
    localparam int RAM_AW = 10;
    localparam int ADDR_W = 16;
    localparam int NWORDS = 1024;

    logic              clk;
    logic              reset;
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic [DATA_W-1:0] io_in;
    logic [DATA_W-1:0] io_out;

    mem_port_ctrl #(.DATA_W(DATA_W), .RAM_AW(RAM_AW), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ack      (ack),
        .busy     (busy),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .io_in    (io_in),
        .io_out   (io_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for dpram port A: synchronous write, registered read.
    logic [DATA_W-1:0] tb_mem [0:NWORDS-1];
    always @(posedge clk) begin
        if (ram_we) tb_mem[ram_addr] <= ram_din;
        ram_dout <= tb_mem[ram_addr];
    end

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] io_out;
        int                we_pulses;
        int                ram_idx;
        logic [DATA_W-1:0] din;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: memory contents, last load result, I/O register.
    logic [DATA_W-1:0] ref_mem [0:NWORDS-1];
    logic [DATA_W-1:0] ref_rdata;
    logic [DATA_W-1:0] ref_io_out;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int ack_total = 0;
    int last_ack = 0;
    int prev_ack = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic bit in_window(input logic [ADDR_W-1:0] a);
`ifdef MEM_CTRL_MMIO_EN
        return a >= 16'hFC00;
`else
        return a != a;
`endif
    endfunction

    // Apply one access to the model and queue what the DUT must report at its ack.
    function automatic void model_issue(input bit w, input logic [ADDR_W-1:0] a,
                                        input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] io);
        exp_t e;
        bit   hit;
        int   idx;
        hit = in_window(a);
        idx = int'(a) % NWORDS;
        if (w) begin
            if (hit) ref_io_out = d;
            else     ref_mem[idx] = d;
        end else begin
            ref_rdata = hit ? io : ref_mem[idx];
        end
        e.rdata     = ref_rdata;
        e.io_out    = ref_io_out;
        e.we_pulses = (w && !hit) ? 1 : 0;
        e.ram_idx   = idx;
        e.din       = d;
        exp_q.push_back(e);
    endfunction

    // Monitor: count strobes and busy cycles per access, and compare against the scoreboard on every ack.
    initial begin
        int                we_cnt;
        int                busy_cnt;
        logic [RAM_AW-1:0] cap_addr;
        logic [DATA_W-1:0] cap_din;
        exp_t              e;
        we_cnt   = 0;
        busy_cnt = 0;
        cap_addr = '0;
        cap_din  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                we_cnt   = 0;
                busy_cnt = 0;
            end else begin
                if (ram_we) begin
                    we_cnt++;
                    cap_addr = ram_addr;
                    cap_din  = ram_din;
                end
                if (busy) busy_cnt++;
                if (ack) begin
                    ack_total++;
                    prev_ack = last_ack;
                    last_ack = cyc;
                    if (exp_q.size() == 0) begin
                        cmp_cnt++;
                        err_cnt++;
                        $display("FAIL unexpected_ack: ack seen with no access outstanding (cycle %0d)", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("rdata", rdata, e.rdata);
                        check("io_out", io_out, e.io_out);
                        check("ram_we_pulses", we_cnt, e.we_pulses);
                        check("busy_cycles", busy_cnt, 3);
                        if (e.we_pulses == 1) begin
                            check("ram_addr", cap_addr, e.ram_idx);
                            check("ram_din", cap_din, e.din);
                        end
                    end
                    we_cnt   = 0;
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic do_access(input bit w, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] io);
        int n;
        @(negedge clk);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        io_in = io;
        model_issue(w, a, d, io);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 20);
        if (!ack) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL ack_timeout: no ack within %0d cycles for addr %0h", n, a);
        end
        req = 1'b0;
    endtask

    task automatic check_hold();
        repeat (2) @(negedge clk);
        check("rdata_hold", rdata, ref_rdata);
    endtask

    initial begin
        int snap;
        int cls;
        logic [ADDR_W-1:0] ra;
        for (int i = 0; i < NWORDS; i++) begin
            tb_mem[i]  = '0;
            ref_mem[i] = '0;
        end
        ref_rdata  = '0;
        ref_io_out = '0;
        reset = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        io_in = '0;
        repeat (3) @(negedge clk);
        check("reset_rdata", rdata, 0);
        check("reset_ack", ack, 0);
        check("reset_busy", busy, 0);
        check("reset_ram_we", ram_we, 0);
        check("reset_ram_addr", ram_addr, 0);
        check("reset_ram_din", ram_din, 0);
        check("reset_io_out", io_out, 0);
        reset = 1'b0;

        // Store then load back, and the load result persists after req drops.
        do_access(1'b1, 16'h0005, 16'hBEEF, 16'h0000);
        do_access(1'b0, 16'h0005, 16'h0000, 16'h0000);
        check_hold();

        // Last RAM word and the alias of word 0.
        do_access(1'b1, 16'h03FF, 16'h1234, 16'h0000);
        do_access(1'b0, 16'h03FF, 16'h0000, 16'h0000);
        do_access(1'b1, 16'h0400, 16'h7777, 16'h0000);
        do_access(1'b0, 16'h0000, 16'h0000, 16'h0000);

        // Top of address space: I/O window when enabled, otherwise alias of word 0x3FF.
        do_access(1'b1, 16'hFFFF, 16'h00A5, 16'h0000);
        check("io_out_after_top_store", io_out, ref_io_out);
        do_access(1'b0, 16'hFC00, 16'h0000, 16'h5A5A);
        do_access(1'b0, 16'h03FF, 16'h0000, 16'h0000);

        // Request held for six cycles with the address changed mid-access.
        snap = ack_total;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 16'h1111;
        model_issue(1'b1, 16'h0020, 16'h1111, io_in);
        repeat (2) @(negedge clk);
        addr = 16'h0031; wdata = 16'h2222;
        model_issue(1'b1, 16'h0031, 16'h2222, io_in);
        repeat (4) @(negedge clk);
        req = 1'b0;
        repeat (4) @(negedge clk);
        check("held_ack_count", ack_total - snap, 2);
        check("held_ack_spacing", last_ack - prev_ack, 4);
        do_access(1'b0, 16'h0020, 16'h0000, 16'h0000);
        do_access(1'b0, 16'h0031, 16'h0000, 16'h0000);

        // Reset while a store sits in ACCESS: strobe drops at once and no ack follows.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 16'h0010; wdata = 16'hDEAD;
        @(negedge clk);
        req = 1'b0;
        check("abort_we_before", ram_we, 1);
        #1 reset = 1'b1;
        #1;
        check("abort_ram_we", ram_we, 0);
        check("abort_ack", ack, 0);
        check("abort_busy", busy, 0);
        check("abort_rdata", rdata, 0);
        check("abort_io_out", io_out, 0);
        ref_rdata  = '0;
        ref_io_out = '0;
        snap = ack_total;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_ack", ack_total, snap);
        do_access(1'b0, 16'h0010, 16'h0000, 16'h0000);

        // Randomised traffic across RAM, aliases and the top window.
        for (int i = 0; i < 150; i++) begin
            cls = $urandom_range(0, 2);
            case (cls)
                0:       ra = ADDR_W'($urandom_range(0, 16'h03FF));
                1:       ra = ADDR_W'($urandom_range(16'h0400, 16'hFBFF));
                default: ra = ADDR_W'($urandom_range(16'hFC00, 16'hFFFF));
            endcase
            do_access(1'($urandom_range(0, 1)), ra, DATA_W'($urandom), DATA_W'($urandom));
            if ($urandom_range(0, 3) == 0) check_hold();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (6) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
